bcd_to_bin: RTL
===============

BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 SHALL have parameters: NUM_DIGITS, default 8, BCD digit count; WIDTH, default 32, binary result width.
REQ-002 SHALL have port: clock  input  1  one clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  conversion request, sampled in IDLE only.
REQ-005 SHALL have ports: first..eighth  input  4 each  BCD digits; first = units, eighth = 10^7.
REQ-006 SHALL have port: neg  input  1  sign of the decimal value; 1 = negative.
REQ-007 SHALL have port: binary  output  32  two's-complement result, registered.
REQ-008 SHALL have port: busy  output  1  high while a conversion is in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when binary/error are valid.
REQ-010 SHALL have port: error  output  1  the last request held a digit > 9; valid with done.

Function
REQ-011 SHALL use an FSM with states IDLE, SHIFT and FINISH.
REQ-012 In IDLE with start=1 at edge E0, SHALL capture {eighth..first} into a 32-bit BCD register and neg into a sign register, clear the 32-bit binary shift register, clear the 5-bit iteration counter, and set busy.
REQ-013 SHALL validate the digits at E0; if any digit > 9, SHALL set error_pending and go to FINISH instead of SHIFT.
REQ-014 Each SHIFT cycle SHALL shift {bcd, bin} right by one as a 64-bit unit: bcd[0] moves into bin[31], and 0 moves into bcd[31].
REQ-015 After the shift in the same cycle, each 4-bit BCD digit >= 8 SHALL have 3 subtracted from it.
REQ-016 SHALL perform exactly 32 SHIFT iterations, at E1..E32, then enter FINISH.
REQ-017 At the FINISH edge (E33), SHALL load binary with bin, or with (~bin + 1) when the sign register is 1.
REQ-018 At E33, SHALL set done=1 and error=error_pending, clear busy, and return to IDLE.
REQ-019 On an invalid request (REQ-013), the FINISH edge SHALL load binary=0 and error=1; done follows at E1.
REQ-020 neg=1 with all digits zero SHALL yield binary=0; no negative zero.
REQ-021 done SHALL be high for exactly one cycle per accepted request.
REQ-022 binary and error SHALL hold their values until the next FINISH edge.
REQ-023 start while busy=1 SHALL be ignored and not queued.
REQ-024 Input digit and neg changes after E0 SHALL NOT affect the result.
REQ-025 start in the cycle done is high SHALL be accepted, because the FSM is then in IDLE.
REQ-026 The maximum magnitude of 99,999,999 SHALL fit in 27 bits; no overflow flag is required.

Reset
REQ-027 reset_n=0 SHALL immediately force the FSM to IDLE, regardless of clock.
REQ-028 reset_n=0 SHALL force binary=0, busy=0, done=0 and error=0.
REQ-029 reset_n=0 SHALL clear the internal counter, shift registers, sign register and error_pending.
REQ-030 Reset during SHIFT or FINISH SHALL abort the conversion with no done pulse.
REQ-031 After reset_n deasserts, the first start SHALL be honored at the next clock edge.

Structure
REQ-032 A shared package SHALL hold the FSM state typedef, NUM_DIGITS=8, WIDTH=32, ITERATIONS=32 and the correction constants THRESH=8 and ADJ=3.
REQ-033 SHALL instantiate one sub-module, bcd_sub3, NUM_DIGITS times: a 4-bit digit correction that subtracts 3 when the input is >= 8 and passes it through otherwise.
REQ-034 Counter, FSM and output registers SHALL be inside bcd_to_bin; no other sub-modules.

Verification
REQ-035 Digits 1,2,3,4,5,6,7,8 (eighth..first), neg=0, start -> done exactly 33 cycles after the start edge, binary=0x00BC614E, error=0.
REQ-036 Digits all 9, neg=0 -> binary=0x05F5E0FF; then neg=1 with digits 00000001 -> binary=0xFFFFFFFF.
REQ-037 Digit third=4'hA, start -> done one cycle later with error=1 and binary=0; busy high for 1 cycle only.
REQ-038 All digits 0 with neg=1 -> binary=0x00000000, error=0.
REQ-039 start pulsed again at cycle 10 of a conversion with different digits -> ignored; the first result is reported and only one done pulse occurs.
REQ-040 reset_n asserted at cycle 15 of a conversion -> all outputs 0 immediately and no done; a new start of 00000042 -> binary=0x0000002A.

Source files
------------

// File: rtl/bcd_to_bin_pkg.sv
// Shared types and constants for the BCD-to-binary converter: FSM states,
// default sizes, iteration count and the per-digit correction constants.
package bcd_to_bin_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 8;
  localparam int WIDTH      = 32;
  localparam int ITERATIONS = 32;

  localparam logic [3:0] THRESH = 4'd8;
  localparam logic [3:0] ADJ    = 4'd3;

endpackage

// File: rtl/bcd_sub3.sv
// One-digit correction step of the reverse double-dabble: after a right shift,
// a digit that reached THRESH or above is pulled back by ADJ.
module bcd_sub3
  import bcd_to_bin_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] fixed
);

  assign fixed = (digit >= THRESH) ? (digit - ADJ) : digit;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential 8-digit signed BCD to two's-complement binary converter using the
// shift-right / subtract-3 algorithm, one bit per clock.
module bcd_to_bin #(
  parameter int NUM_DIGITS = bcd_to_bin_pkg::NUM_DIGITS,
  parameter int WIDTH      = bcd_to_bin_pkg::WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       first,
  input  logic [3:0]       second,
  input  logic [3:0]       third,
  input  logic [3:0]       fourth,
  input  logic [3:0]       fifth,
  input  logic [3:0]       sixth,
  input  logic [3:0]       seventh,
  input  logic [3:0]       eighth,
  input  logic             neg,
  output logic [WIDTH-1:0] binary,
  output logic             busy,
  output logic             done,
  output logic             error
);

  import bcd_to_bin_pkg::*;

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam logic [4:0] LAST_ITER = 5'(ITERATIONS - 1);

  state_t           state;
  logic [BCD_W-1:0] bcd_q;
  logic [WIDTH-1:0] bin_q;
  logic             sign_q;
  logic             error_pending;
  logic [4:0]       cnt;

  logic [BCD_W-1:0] bcd_in;
  logic [BCD_W-1:0] bcd_shr;
  logic [BCD_W-1:0] bcd_adj;
  logic [WIDTH-1:0] bin_shr;
  logic             bad_digit;

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                  input logic             is_neg);
    logic signed [WIDTH-1:0] s_mag;
    s_mag = signed'(mag);
    return is_neg ? unsigned'(-s_mag) : mag;
  endfunction

  assign bcd_in = {eighth, seventh, sixth, fifth, fourth, third, second, first};

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // The {bcd, bin} pair shifts right as one word; each digit is then corrected.
  assign bcd_shr = {1'b0, bcd_q[BCD_W-1:1]};
  assign bin_shr = {bcd_q[0], bin_q[WIDTH-1:1]};

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_fix
    bcd_sub3 u_sub3 (
      .digit (bcd_shr[4*g +: 4]),
      .fixed (bcd_adj[4*g +: 4])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      bcd_q         <= '0;
      bin_q         <= '0;
      sign_q        <= 1'b0;
      error_pending <= 1'b0;
      cnt           <= '0;
      binary        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bcd_q         <= bcd_in;
            sign_q        <= neg;
            bin_q         <= '0;
            cnt           <= '0;
            busy          <= 1'b1;
            error_pending <= bad_digit;
            state         <= bad_digit ? FINISH : SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_adj;
          bin_q <= bin_shr;
          cnt   <= cnt + 5'd1;
          if (cnt == LAST_ITER) state <= FINISH;
        end
        FINISH: begin
          // Negating a zero magnitude stays zero, so no negative zero appears.
          binary <= error_pending ? '0 : apply_sign(bin_q, sign_q);
          error  <= error_pending;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
